// File: rtl/spi_slave.sv
// spi_slave: SPI responder oversampled in the sclk domain.
// Received bytes are strobed out; transmit bytes come from a one-entry buffer.
module spi_slave #(
   parameter logic       CPOL        = 1'b0,
   parameter logic       CPHA        = 1'b0,
   parameter logic       LSB_FIRST   = 1'b1,
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] FILL        = 8'hFF
) (
   input  logic       sclk,
   input  logic       rst,
   input  logic       spi_sck,
   input  logic       spi_ss_n,
   input  logic       spi_mosi,
   output logic       spi_miso,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       busy,
   output logic       tx_underrun,
   output logic       frame_err
);

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("SYNC_STAGES must be at least 2");
   end

   typedef enum logic {
      IDLE,
      ACTIVE
   } state_t;

   logic [SYNC_STAGES-1:0] sck_sync_q;
   logic [SYNC_STAGES-1:0] ss_sync_q;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic [SYNC_STAGES:0]   vld_q;
   logic                   sck_cur_q;
   logic                   sck_hist_q;
   logic                   ss_cur_q;
   logic                   ss_hist_q;
   logic                   mosi_cur_q;
   logic                   armed_q;

   always_ff @(posedge sclk) begin
      if (!rst) begin
         sck_sync_q  <= {SYNC_STAGES{CPOL}};
         ss_sync_q   <= '1;
         mosi_sync_q <= '0;
         vld_q       <= '0;
         sck_cur_q   <= CPOL;
         sck_hist_q  <= CPOL;
         ss_cur_q    <= 1'b1;
         ss_hist_q   <= 1'b1;
         mosi_cur_q  <= 1'b0;
         armed_q     <= 1'b0;
      end else begin
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
         ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi_ss_n};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
         vld_q       <= {vld_q[SYNC_STAGES-1:0], 1'b1};
         sck_cur_q   <= sck_sync_q[SYNC_STAGES-1];
         sck_hist_q  <= sck_cur_q;
         ss_cur_q    <= ss_sync_q[SYNC_STAGES-1];
         ss_hist_q   <= ss_cur_q;
         mosi_cur_q  <= mosi_sync_q[SYNC_STAGES-1];
         // A frame may only start once a genuine high on ss_n was seen.
         armed_q     <= armed_q | (vld_q[SYNC_STAGES] & ss_cur_q);
      end
   end

   logic sck_chg;
   logic sck_lead;
   logic sck_trail;
   logic sample_ev;
   logic shift_ev;
   logic ss_fall;
   logic ss_rise;

   assign sck_chg   = sck_cur_q ^ sck_hist_q;
   assign sck_lead  = sck_chg & (sck_cur_q != CPOL);
   assign sck_trail = sck_chg & (sck_cur_q == CPOL);
   assign sample_ev = CPHA ? sck_trail : sck_lead;
   assign shift_ev  = CPHA ? sck_lead : sck_trail;
   assign ss_fall   = armed_q & ss_hist_q & ~ss_cur_q;
   assign ss_rise   = ss_cur_q & ~ss_hist_q;

   function automatic logic first_bit(input logic [7:0] b);
      return LSB_FIRST ? b[0] : b[7];
   endfunction

   function automatic logic [7:0] advance(input logic [7:0] b);
      return LSB_FIRST ? {1'b0, b[7:1]} : {b[6:0], 1'b0};
   endfunction

   state_t     state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] rx_sr_q, rx_sr_d;
   logic [7:0] tx_sr_q, tx_sr_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic [7:0] buf_q, buf_d;
   logic       buf_full_q, buf_full_d;
   logic       miso_q, miso_d;
   logic       rx_valid_q, rx_valid_d;
   logic       under_q, under_d;
   logic       ferr_q, ferr_d;
   logic       load;
   logic       wr;
   logic [7:0] load_byte;
   logic [7:0] rx_shift;

   assign load_byte = buf_full_q ? buf_q : FILL;
   assign rx_shift  = LSB_FIRST ? {mosi_cur_q, rx_sr_q[7:1]}
                                : {rx_sr_q[6:0], mosi_cur_q};

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      rx_sr_d    = rx_sr_q;
      tx_sr_d    = tx_sr_q;
      rx_data_d  = rx_data_q;
      miso_d     = miso_q;
      rx_valid_d = 1'b0;
      ferr_d     = 1'b0;
      load       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (ss_fall) begin
               state_d   = ACTIVE;
               bit_cnt_d = 3'd0;
               rx_sr_d   = 8'h00;
               load      = 1'b1;
               if (CPHA) begin
                  tx_sr_d = load_byte;
               end else begin
                  miso_d  = first_bit(load_byte);
                  tx_sr_d = advance(load_byte);
               end
            end
         end
         ACTIVE: begin
            if (ss_rise) begin
               state_d   = IDLE;
               ferr_d    = (bit_cnt_q != 3'd0);
               bit_cnt_d = 3'd0;
               rx_sr_d   = 8'h00;
            end else if (sample_ev) begin
               rx_sr_d = rx_shift;
               if (bit_cnt_q == 3'd7) begin
                  rx_data_d  = rx_shift;
                  rx_valid_d = 1'b1;
                  bit_cnt_d  = 3'd0;
                  load       = 1'b1;
                  tx_sr_d    = load_byte;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end else if (shift_ev) begin
               miso_d  = first_bit(tx_sr_q);
               tx_sr_d = advance(tx_sr_q);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // An empty-buffer consume takes FILL; a same-cycle write stays buffered.
   assign wr      = tx_valid & ~buf_full_q;
   assign under_d = load & ~buf_full_q;

   always_comb begin
      buf_full_d = buf_full_q;
      buf_d      = buf_q;
      if (load && buf_full_q) begin
         buf_full_d = 1'b0;
      end
      if (wr) begin
         buf_full_d = 1'b1;
         buf_d      = tx_data;
      end
   end

   always_ff @(posedge sclk) begin
      if (!rst) begin
         state_q    <= IDLE;
         bit_cnt_q  <= 3'd0;
         rx_sr_q    <= 8'h00;
         tx_sr_q    <= 8'h00;
         rx_data_q  <= 8'h00;
         buf_q      <= 8'h00;
         buf_full_q <= 1'b0;
         miso_q     <= 1'b0;
         rx_valid_q <= 1'b0;
         under_q    <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         rx_sr_q    <= rx_sr_d;
         tx_sr_q    <= tx_sr_d;
         rx_data_q  <= rx_data_d;
         buf_q      <= buf_d;
         buf_full_q <= buf_full_d;
         miso_q     <= miso_d;
         rx_valid_q <= rx_valid_d;
         under_q    <= under_d;
         ferr_q     <= ferr_d;
      end
   end

   assign busy        = (state_q == ACTIVE);
   assign spi_miso    = busy ? miso_q : 1'bz;
   assign tx_ready    = ~buf_full_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign tx_underrun = under_q;
   assign frame_err   = ferr_q;

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed SPI master stimulus against two responders
// (mode 0 LSB-first, mode 3 MSB-first) with a byte-level model.
module tb_spi_slave;

   localparam int S = 2;
   localparam int H = 17;

   logic       sclk  = 1'b0;
   logic       rst   = 1'b0;
   logic       sck   = 1'b0;
   logic       mosi  = 1'b0;
   logic       ss_a  = 1'b1;
   logic       ss_b  = 1'b1;
   logic       txv_a = 1'b0;
   logic       txv_b = 1'b0;
   logic [7:0] txd   = 8'h00;

   wire        miso_a;
   wire        miso_b;
   // A released line reads back as 1.
   pullup (miso_a);
   pullup (miso_b);

   logic [7:0] rxd_a, rxd_b;
   logic       txr_a, txr_b;
   logic       rxv_a, rxv_b;
   logic       busy_a, busy_b;
   logic       und_a, und_b;
   logic       ferr_a, ferr_b;

   always #5 sclk = ~sclk;

   spi_slave u_a (
      .sclk(sclk), .rst(rst), .spi_sck(sck), .spi_ss_n(ss_a),
      .spi_mosi(mosi), .spi_miso(miso_a), .tx_data(txd),
      .tx_valid(txv_a), .tx_ready(txr_a), .rx_data(rxd_a),
      .rx_valid(rxv_a), .busy(busy_a), .tx_underrun(und_a),
      .frame_err(ferr_a)
   );

   spi_slave #(
      .CPOL(1'b1), .CPHA(1'b1), .LSB_FIRST(1'b0)
   ) u_b (
      .sclk(sclk), .rst(rst), .spi_sck(sck), .spi_ss_n(ss_b),
      .spi_mosi(mosi), .spi_miso(miso_b), .tx_data(txd),
      .tx_valid(txv_b), .tx_ready(txr_b), .rx_data(rxd_b),
      .rx_valid(rxv_b), .busy(busy_b), .tx_underrun(und_b),
      .frame_err(ferr_b)
   );

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0] rxq[2][$];
   logic [7:0] bufq[2][$];
   logic [7:0] cur_exp[2];
   int         exp_und[2];
   int         got_und[2];
   int         exp_ferr[2];
   int         got_ferr[2];
   logic       pv[2], pu[2], pf[2];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
      end
   endtask

   task automatic model_write(input int d, input logic [7:0] v);
      bufq[d].push_back(v);
   endtask

   task automatic model_load(input int d);
      if (bufq[d].size() > 0) begin
         cur_exp[d] = bufq[d].pop_front();
      end else begin
         cur_exp[d] = 8'hFF;
         exp_und[d]++;
      end
   endtask

   task automatic mon(input int d, input logic v, input logic [7:0] data,
                      input logic bz, input logic m, input logic u,
                      input logic f);
      if (v) begin
         if (rxq[d].size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL rx_valid_unexpected dut%0d: got strobe with 0x%02h, required none",
                     d, data);
         end else begin
            chk($sformatf("rx_data_dut%0d", d), data, rxq[d].pop_front());
         end
      end
      if (!bz) chk($sformatf("miso_released_dut%0d", d), m, 1);
      if (pv[d]) chk($sformatf("rx_valid_width_dut%0d", d), v, 0);
      if (pu[d]) chk($sformatf("underrun_width_dut%0d", d), u, 0);
      if (pf[d]) chk($sformatf("frame_err_width_dut%0d", d), f, 0);
      if (u) got_und[d]++;
      if (f) got_ferr[d]++;
      pv[d] = v;
      pu[d] = u;
      pf[d] = f;
   endtask

   always @(negedge sclk) begin
      if (rst) begin
         mon(0, rxv_a, rxd_a, busy_a, miso_a, und_a, ferr_a);
         mon(1, rxv_b, rxd_b, busy_b, miso_b, und_b, ferr_b);
      end else begin
         pv = '{1'b0, 1'b0};
         pu = '{1'b0, 1'b0};
         pf = '{1'b0, 1'b0};
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge sclk);
   endtask

   task automatic set_ss(input int d, input logic v);
      if (d == 0) ss_a = v;
      else ss_b = v;
   endtask

   task automatic write(input int d, input logic [7:0] v);
      txd = v;
      if (d == 0) txv_a = 1'b1;
      else txv_b = 1'b1;
      wait_cyc(1);
      txv_a = 1'b0;
      txv_b = 1'b0;
      model_write(d, v);
   endtask

   task automatic frame_begin(input int d);
      model_load(d);
      set_ss(d, 1'b0);
      wait_cyc(H);
   endtask

   task automatic frame_end(input int d);
      wait_cyc(H);
      set_ss(d, 1'b1);
      wait_cyc(12);
   endtask

   task automatic xfer(input int d, input logic [7:0] tx, input int nbits,
                       output logic [7:0] rx);
      logic cpol, cpha, lsb;
      int   idx;
      cpol = (d == 1);
      cpha = (d == 1);
      lsb  = (d == 0);
      rx   = 8'h00;
      if (nbits == 8) rxq[d].push_back(tx);
      for (int i = 0; i < nbits; i++) begin
         idx = lsb ? i : 7 - i;
         if (!cpha) begin
            mosi = tx[idx];
            wait_cyc(H);
            sck = ~cpol;
            rx[idx] = (d == 0) ? miso_a : miso_b;
            wait_cyc(H);
            sck = cpol;
         end else begin
            sck  = ~cpol;
            mosi = tx[idx];
            wait_cyc(H);
            sck = cpol;
            rx[idx] = (d == 0) ? miso_a : miso_b;
            wait_cyc(H);
         end
      end
      if (nbits == 8) begin
         chk($sformatf("miso_byte_dut%0d", d), rx, cur_exp[d]);
         model_load(d);
      end
   endtask

   task automatic reset_chk(input string tag);
      chk({tag, "_rx_data_a"}, rxd_a, 8'h00);
      chk({tag, "_rx_valid_a"}, rxv_a, 0);
      chk({tag, "_busy_a"}, busy_a, 0);
      chk({tag, "_tx_ready_a"}, txr_a, 1);
      chk({tag, "_underrun_a"}, und_a, 0);
      chk({tag, "_frame_err_a"}, ferr_a, 0);
      chk({tag, "_miso_a"}, miso_a, 1);
      chk({tag, "_busy_b"}, busy_b, 0);
      chk({tag, "_tx_ready_b"}, txr_b, 1);
      chk({tag, "_rx_data_b"}, rxd_b, 8'h00);
   endtask

   logic [7:0] r, r1, r2;

   initial begin
      exp_und  = '{0, 0};
      got_und  = '{0, 0};
      exp_ferr = '{0, 0};
      got_ferr = '{0, 0};
      pv = '{1'b0, 1'b0};
      pu = '{1'b0, 1'b0};
      pf = '{1'b0, 1'b0};
      wait_cyc(4);
      reset_chk("reset");
      rst = 1'b1;
      wait_cyc(10);

      // single byte, mode 0
      write(0, 8'hA5);
      chk("t1_tx_ready_after_write", txr_a, 0);
      frame_begin(0);
      chk("t1_tx_ready_after_fall", txr_a, 1);
      chk("t1_busy", busy_a, 1);
      xfer(0, 8'h3C, 8, r);
      chk("t1_miso_literal", r, 8'hA5);
      frame_end(0);
      chk("t1_rx_data", rxd_a, 8'h3C);
      chk("t1_busy_end", busy_a, 0);

      // two-byte frame, buffer empty for byte 2
      write(0, 8'h81);
      frame_begin(0);
      xfer(0, 8'h12, 8, r1);
      xfer(0, 8'h34, 8, r2);
      frame_end(0);
      chk("t2_miso_b1_literal", r1, 8'h81);
      chk("t2_miso_b2_literal", r2, 8'hFF);
      chk("t2_rx_data", rxd_a, 8'h34);
      chk("t2_underruns", got_und[0], exp_und[0]);

      // aborted byte after 5 bits
      frame_begin(0);
      xfer(0, 8'hE7, 5, r);
      exp_ferr[0]++;
      frame_end(0);
      chk("t3_frame_err", got_ferr[0], exp_ferr[0]);
      chk("t3_rx_data_kept", rxd_a, 8'h34);
      chk("t3_busy", busy_a, 0);
      chk("t3_miso_released", miso_a, 1);

      // reset mid-frame
      frame_begin(0);
      xfer(0, 8'hFF, 3, r);
      rst = 1'b0;
      wait_cyc(2);
      reset_chk("t4_reset");
      bufq[0].delete();
      rst = 1'b1;
      xfer(0, 8'h00, 5, r);
      frame_end(0);
      chk("t4_frame_err_none", got_ferr[0], exp_ferr[0]);
      frame_begin(0);
      xfer(0, 8'h5A, 8, r);
      frame_end(0);
      chk("t4_rx_data", rxd_a, 8'h5A);
      chk("t4_miso_literal", r, 8'hFF);

      // write lands on the cycle of the ss_n fall
      model_load(0);
      model_write(0, 8'h77);
      ss_a = 1'b0;
      wait_cyc(S + 1);
      txd   = 8'h77;
      txv_a = 1'b1;
      wait_cyc(1);
      txv_a = 1'b0;
      chk("t5_buffer_held", txr_a, 0);
      wait_cyc(H - S - 2);
      xfer(0, 8'h11, 8, r1);
      xfer(0, 8'h22, 8, r2);
      frame_end(0);
      chk("t5_miso_b1_literal", r1, 8'hFF);
      chk("t5_miso_b2_literal", r2, 8'h77);
      chk("t5_rx_data", rxd_a, 8'h22);

      // mode 3, MSB first
      sck = 1'b1;
      wait_cyc(10);
      write(1, 8'hC3);
      frame_begin(1);
      xfer(1, 8'h96, 8, r);
      frame_end(1);
      chk("t6_miso_literal", r, 8'hC3);
      chk("t6_rx_data", rxd_b, 8'h96);

      wait_cyc(5);
      chk("rx_pending_a", rxq[0].size(), 0);
      chk("rx_pending_b", rxq[1].size(), 0);
      chk("underruns_a", got_und[0], exp_und[0]);
      chk("underruns_b", got_und[1], exp_und[1]);
      chk("frame_errs_a", got_ferr[0], exp_ferr[0]);
      chk("frame_errs_b", got_ferr[1], exp_ferr[1]);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: bench still running at time limit");
      $fatal(1);
   end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI responder for the FPGA test designs. It is the far end of the team's SPI master and lets one FPGA answer another over the same four-wire bus. The SPI pins are oversampled in the `sclk` system clock domain, and received bytes are deserialized and presented on a valid strobe. Transmit bytes are taken from a one-entry holding buffer through a valid/ready handshake. Frames may carry any number of bytes while `spi_ss_n` stays low.

## Interface
- `CPOL`, default 0: idle level of `spi_sck`.
- `CPHA`, default 0: 0 samples on the leading edge and shifts on the trailing edge; 1 does the opposite.
- `LSB_FIRST`, default 1: bit order on the wire. With 1, bit 0 goes first, matching the team master.
- `SYNC_STAGES`, default 2: synchronizer flops on `spi_sck`, `spi_ss_n` and `spi_mosi`. Minimum 2.
- `FILL`, default 8'hFF: byte sent when the holding buffer is empty at byte start.

Ports (name, direction, width, meaning):
- `sclk` in 1: system clock. All logic is on its rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `spi_sck` in 1: SPI clock from the master, asynchronous.
- `spi_ss_n` in 1: slave select, active-low, asynchronous.
- `spi_mosi` in 1: master-out data, asynchronous.
- `spi_miso` out 1: slave-out data. Driven only while selected, 1'bz otherwise.
- `tx_data` in 8: next byte to send.
- `tx_valid` in 1: `tx_data` is offered.
- `tx_ready` out 1: holding buffer is empty. A transfer occurs when `tx_valid & tx_ready`.
- `rx_data` out 8: last received byte. Holds until the next byte completes.
- `rx_valid` out 1: one-cycle pulse when `rx_data` updates.
- `busy` out 1: frame in progress (state ACTIVE).
- `tx_underrun` out 1: one-cycle pulse when `FILL` was loaded.
- `frame_err` out 1: one-cycle pulse when `spi_ss_n` rises mid-byte.

## Operation
- **Synchronization.** Each SPI input passes through `SYNC_STAGES` flops, then one history flop for edge detection. Sync flops reset to `spi_sck`=`CPOL`, `spi_ss_n`=1, `spi_mosi`=0.
- **Edge definitions.**
  - Leading edge is the transition away from `CPOL`; trailing edge is the transition back.
  - The sample edge is the leading edge when `CPHA`=0, else the trailing edge. The shift edge is the other one.
- **States.** Two: IDLE and ACTIVE.
- **IDLE.**
  - `spi_miso`=z, `busy`=0.
  - A synchronized falling edge of `spi_ss_n` moves to ACTIVE, with these actions in the same cycle:
    - Clear `bit_cnt`.
    - Load the tx shift register: from the buffer if it is full (buffer becomes empty), else from `FILL` with a `tx_underrun` pulse.
  - If `CPHA`=0, drive the first bit immediately.
  - A level-low `spi_ss_n` without a falling edge does not start a frame. This covers the case after reset.
- **ACTIVE, sample edge.**
  - Shift the synchronized `spi_mosi` into the rx shift register in wire order.
  - `bit_cnt` increments.
  - On the 8th sample: write the assembled byte to `rx_data`, pulse `rx_valid`, clear `bit_cnt`, and reload the tx shift register as at frame start.
- **ACTIVE, shift edge.** Drive the next tx bit on `spi_miso`.
  - `CPHA`=1: the first shift edge of each byte drives bit 0 of the newly loaded byte (bit 7 when `LSB_FIRST`=0).
  - `CPHA`=0: the shift edge that follows the 8th sample edge drives the first bit of the reloaded byte.
- **ACTIVE, `spi_ss_n` rises.**
  - Return to IDLE and set `spi_miso`=z.
  - If `bit_cnt`≠0, pulse `frame_err` and discard the partial byte; `rx_data` is unchanged.
  - A tx byte already loaded into the shift register is lost. The holding buffer is untouched.
- **Holding buffer.**
  - `tx_ready` = buffer empty.
  - If a write and a consume happen in the same cycle (buffer empty), the consume takes `FILL` and the written byte stays buffered for the next byte.
  - A full buffer cannot be written, so a full-buffer consume never coincides with a write.
- **Reset** (`rst`=0 at a `sclk` edge), at any time including mid-frame:
  - State IDLE; shift registers, `bit_cnt` and buffer cleared.
  - `rx_data`=0; `rx_valid`=`tx_underrun`=`frame_err`=`busy`=0; `tx_ready`=1; `spi_miso`=z.

## Timing
- A pin transition is recognized as an edge event in cycle `SYNC_STAGES`+1 after the first `sclk` edge that samples it.
- The resulting register updates are visible `SYNC_STAGES`+2 cycles after that first sampling edge:
  - `rx_valid`/`rx_data` after the 8th sample edge;
  - `spi_miso` after a shift edge or after the `spi_ss_n` fall;
  - `busy`, and `frame_err` after the `spi_ss_n` rise.
- `rx_valid`, `tx_underrun` and `frame_err` are exactly one cycle wide.
- `tx_ready` falls the cycle after an accepted write and rises the cycle after a consume.
- Bus constraints:
  - `spi_sck` high and low times must each be at least `SYNC_STAGES`+3 `sclk` cycles.
  - With `CPHA`=0, the first sample edge must come at least `SYNC_STAGES`+3 cycles after the `spi_ss_n` fall.
  - The team master (divider 16, i.e. 17 cycles per half period) meets both at the default `SYNC_STAGES`.

## Test plan
- **Single byte, mode 0.** Defaults; write 0xA5; master sends 0x3C LSB first.
  - `rx_data`=0x3C with one `rx_valid` pulse.
  - `spi_miso` bits 1,0,1,0,0,1,0,1.
  - `tx_ready` low after the write, high after the `spi_ss_n` fall.
- **Two-byte frame, empty buffer on byte 2.** Write 0x81; master sends 0x12 then 0x34 in one frame.
  - `rx_valid` pulses twice with 0x12 then 0x34.
  - MISO returns 0x81 then 0xFF, with one `tx_underrun` pulse at the byte-2 reload.
- **Aborted byte.** `spi_ss_n` rises after 5 bits.
  - `frame_err` pulses; no `rx_valid`; `rx_data` keeps its previous value; `spi_miso`=z; `busy`=0.
- **Reset mid-frame.** After 3 bits, assert `rst` while `spi_ss_n` stays low.
  - All outputs take their reset values.
  - Remaining clocks produce no `rx_valid`.
  - The next frame (0x5A) is received correctly.
- **Write coinciding with consume.** `tx_valid` with 0x77 lands on the cycle of the `spi_ss_n` fall, buffer empty.
  - Byte 1 sends 0xFF with a `tx_underrun` pulse; byte 2 sends 0x77.
- **Mode 3, MSB first.** `CPOL`=1, `CPHA`=1, `LSB_FIRST`=0; write 0xC3; master sends 0x96.
  - `rx_data`=0x96; MISO bits 1,1,0,0,0,0,1,1.
